// File: rtl/i2c_write_master.sv
// Single-shot I2C write master: START, three bytes each followed by an ACK clock, STOP.
// Optional build macro I2C_ABORT_ON_NACK_EN: NACK on byte 0 or 1 skips straight to STOP.
module i2c_write_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000,
  parameter int QTR      = CLK_FREQ / (4 * I2C_FREQ)
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [23:0] i2c_data,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int TW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(QTR - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(QTR - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t         state_r, state_nxt;
  logic [1:0]     qtr_r, qtr_nxt;
  logic [2:0]     bit_r, bit_nxt;
  logic [1:0]     byte_r, byte_nxt;
  logic [23:0]    shift_r, shift_nxt;
  logic [TW-1:0]  tick_r, tick_nxt;
  logic           busy_r, busy_nxt;
  logic           done_r, done_nxt;
  logic           ack_err_r, ack_err_nxt;
  logic           scl_r, scl_nxt;
  logic           sda_low_r, sda_low_nxt;
  logic           wrap_s;

  function automatic logic scl_level(input state_t s, input logic [1:0] q);
    case (s)
      S_IDLE:  scl_level = 1'b1;
      S_START: scl_level = (q != 2'd3);
      S_BIT:   scl_level = (q == 2'd1) || (q == 2'd2);
      S_ACK:   scl_level = (q == 2'd1) || (q == 2'd2);
      S_STOP:  scl_level = (q != 2'd0);
      default: scl_level = 1'b1;
    endcase
  endfunction

  function automatic logic sda_pull(input state_t s, input logic [1:0] q, input logic b);
    case (s)
      S_IDLE:  sda_pull = 1'b0;
      S_START: sda_pull = (q != 2'd0);
      S_BIT:   sda_pull = ~b;
      S_ACK:   sda_pull = 1'b0;
      S_STOP:  sda_pull = (q == 2'd0) || (q == 2'd1);
      default: sda_pull = 1'b0;
    endcase
  endfunction

  // Next-state sequencing; pin levels are decoded from the next state so they leave the flops aligned to each quarter.
  always_comb begin
    wrap_s      = (state_r != S_IDLE) && (tick_r == TICK_LAST);
    state_nxt   = state_r;
    qtr_nxt     = qtr_r;
    bit_nxt     = bit_r;
    byte_nxt    = byte_r;
    shift_nxt   = shift_r;
    ack_err_nxt = ack_err_r;
    busy_nxt    = busy_r;
    tick_nxt    = ((state_r == S_IDLE) || wrap_s) ? {TW{1'b0}} : tick_r + TW'(1);
    done_nxt    = (state_r == S_STOP) && (qtr_r == 2'd3) && (tick_r == TICK_PRE);

    case (state_r)
      S_IDLE: begin
        if (go) begin
          state_nxt   = S_START;
          qtr_nxt     = 2'd0;
          bit_nxt     = 3'd0;
          byte_nxt    = 2'd0;
          shift_nxt   = i2c_data;
          ack_err_nxt = 1'b0;
          busy_nxt    = 1'b1;
        end else begin
          state_nxt   = S_IDLE;
        end
      end
      S_START: begin
        if (wrap_s) begin
          if (qtr_r == 2'd3) begin
            state_nxt = S_BIT;
            qtr_nxt   = 2'd0;
            bit_nxt   = 3'd0;
          end else begin
            qtr_nxt   = qtr_r + 2'd1;
          end
        end else begin
          qtr_nxt = qtr_r;
        end
      end
      S_BIT: begin
        if (wrap_s) begin
          if (qtr_r == 2'd3) begin
            shift_nxt = {shift_r[22:0], 1'b0};
            qtr_nxt   = 2'd0;
            if (bit_r == 3'd7) begin
              state_nxt = S_ACK;
              bit_nxt   = 3'd0;
            end else begin
              bit_nxt   = bit_r + 3'd1;
            end
          end else begin
            qtr_nxt = qtr_r + 2'd1;
          end
        end else begin
          qtr_nxt = qtr_r;
        end
      end
      S_ACK: begin
        if (wrap_s) begin
          if (qtr_r == 2'd2) begin
            if (I2C_SDAT == 1'b1) begin
              ack_err_nxt = 1'b1;
            end else begin
              ack_err_nxt = ack_err_r;
            end
          end else begin
            ack_err_nxt = ack_err_r;
          end
          if (qtr_r == 2'd3) begin
            qtr_nxt = 2'd0;
            // ack_err is cleared on acceptance, so when set here it came from this slot.
            if (byte_r == 2'd2) begin
              state_nxt = S_STOP;
`ifdef I2C_ABORT_ON_NACK_EN
            end else if (ack_err_r) begin
              state_nxt = S_STOP;
`endif
            end else begin
              state_nxt = S_BIT;
              byte_nxt  = byte_r + 2'd1;
            end
          end else begin
            qtr_nxt = qtr_r + 2'd1;
          end
        end else begin
          qtr_nxt = qtr_r;
        end
      end
      S_STOP: begin
        if (wrap_s) begin
          if (qtr_r == 2'd3) begin
            state_nxt = S_IDLE;
            qtr_nxt   = 2'd0;
          end else begin
            qtr_nxt   = qtr_r + 2'd1;
          end
        end else begin
          qtr_nxt = qtr_r;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        qtr_nxt   = 2'd0;
      end
    endcase

    // done/busy flip one cycle ahead of the final wrap so they land in that wrap cycle.
    if (done_nxt) begin
      busy_nxt = 1'b0;
    end else begin
      busy_nxt = busy_nxt;
    end

    scl_nxt     = scl_level(state_nxt, qtr_nxt);
    sda_low_nxt = sda_pull(state_nxt, qtr_nxt, shift_nxt[23]);
  end

  // State, counters and registered pin/status outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      qtr_r     <= 2'd0;
      bit_r     <= 3'd0;
      byte_r    <= 2'd0;
      shift_r   <= 24'd0;
      tick_r    <= {TW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      qtr_r     <= qtr_nxt;
      bit_r     <= bit_nxt;
      byte_r    <= byte_nxt;
      shift_r   <= shift_nxt;
      tick_r    <= tick_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      ack_err_r <= ack_err_nxt;
      scl_r     <= scl_nxt;
      sda_low_r <= sda_low_nxt;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign ack_err  = ack_err_r;
  assign I2C_SCLK = scl_r;
  assign I2C_SDAT = sda_low_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: pulled-up SDA, byte-capturing slave with per-byte NACK mask,
// transaction-level expectations for length, ack_err and payload, plus SCL timing monitor.
module tb_i2c_write_master;

  localparam int QTR = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [23:0] i2c_data = 24'd0;
  logic        busy, done, ack_err, scl;
  wire         sda;

  logic        mon_en = 1'b0;
  logic        slave_low = 1'b0;
  logic [2:0]  nack_mask = 3'd0;

  pullup (sda);
  assign sda = (slave_low && mon_en) ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_write_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .i2c_data (i2c_data),
    .go       (go),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: START/STOP detection, MSB-first byte capture, ACK unless masked.
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       in_frame = 1'b0;
  int         bitcnt = 0, byteidx = 0, frame_id = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] cur = 8'd0;
  logic [7:0] cap_q[$];

  always @(scl, sda, mon_en) begin
    if (!mon_en) begin
      in_frame = 1'b0; slave_low = 1'b0; bitcnt = 0;
    end else if (scl_p && scl && sda_p && !sda) begin
      start_cnt++; frame_id++; in_frame = 1'b1; bitcnt = 0; byteidx = 0; slave_low = 1'b0;
    end else if (scl_p && scl && !sda_p && sda) begin
      if (in_frame) stop_cnt++;
      in_frame = 1'b0;
    end else if (!scl_p && scl && in_frame) begin
      if (bitcnt < 8) begin
        cur = {cur[6:0], sda}; bitcnt++;
      end else begin
        cap_q.push_back(cur); bitcnt = 0; byteidx++;
      end
    end else if (scl_p && !scl && in_frame) begin
      if (bitcnt == 8) slave_low = (byteidx < 3) ? !nack_mask[byteidx] : 1'b0;
      else if (bitcnt == 0) slave_low = 1'b0;
    end
    scl_p = scl; sda_p = sda;
  end

  // SCL high/low run lengths inside a frame must each be two quarters.
  logic mscl = 1'b1, rise_ok = 1'b0;
  int   run = 0, rise_fid = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      mscl = scl; run = 0; rise_ok = 1'b0;
    end else if (scl != mscl) begin
      if (mscl && rise_ok && in_frame && rise_fid == frame_id) check_val("scl_high", run, 2*QTR);
      if (!mscl && in_frame) check_val("scl_low", run, 2*QTR);
      rise_ok = scl && in_frame; rise_fid = frame_id; run = 1; mscl = scl;
    end else begin
      run++;
    end
  end

  task automatic check_idle_pins(input string tag);
    check_val({tag, "_scl"}, scl, 1);
    check_val({tag, "_sda"}, sda, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
  endtask

  task automatic run_txn(input logic [23:0] data, input logic [2:0] mask, input bit hold,
                         input int reset_at, input bit pulse100);
    int n_q, n_sent, n_cyc, done_at, done_cnt, busy_bad, s0, p0, c0;
    logic exp_err;
    n_q = 116; n_sent = 3;
`ifdef I2C_ABORT_ON_NACK_EN
    if (mask[0]) begin n_q = 44; n_sent = 1; end
    else if (mask[1]) begin n_q = 80; n_sent = 2; end
`endif
    exp_err = 1'b0;
    for (int i = 0; i < n_sent; i++) if (mask[i]) exp_err = 1'b1;
    n_cyc = n_q * QTR;
    nack_mask = mask;

    @(negedge clk);
    check_val("pre_busy", busy, 0);
    check_val("pre_done", done, 0);
    s0 = start_cnt; p0 = stop_cnt; c0 = cap_q.size();
    go = 1'b1; i2c_data = data;
    done_at = -1; done_cnt = 0; busy_bad = 0;

    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge clk);
      if (!hold && (k == 1 || (pulse100 && k == 101))) go = 1'b0;
      if (pulse100 && k == 100) begin go = 1'b1; i2c_data = $urandom; end
      if (k == 1) check_val("ack_err_clr", ack_err, 0);
      if (k == reset_at) begin
        mon_en = 1'b0;
        go = 1'b0;
        reset = 1'b1;
        #1;
        check_idle_pins("rst_now");
        check_val("rst_ack_err", ack_err, 0);
        repeat (3) @(negedge clk);
        check_idle_pins("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        return;
      end
      if (done) begin
        if (done_at < 0) done_at = k;
        done_cnt++;
      end
      if (k < n_cyc && busy !== 1'b1) busy_bad++;
      if (k == n_cyc) begin
        check_val("busy_at_done", busy, 0);
        check_val("ack_err_at_done", ack_err, exp_err);
      end
    end

    check_val("done_cycle", done_at, n_cyc);
    check_val("done_pulses", done_cnt, 1);
    check_val("busy_gaps", busy_bad, 0);
    check_val("start_count", start_cnt - s0, 1);
    check_val("stop_count", stop_cnt - p0, 1);
    check_val("bytes_sent", cap_q.size() - c0, n_sent);
    for (int i = 0; i < n_sent; i++)
      if (cap_q.size() > c0 + i) check_val("byte_val", cap_q[c0 + i], data[23 - 8*i -: 8]);
  endtask

  initial begin
    logic [23:0] rd;
    logic [2:0]  rm;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_pins("reset");
    check_val("reset_ack_err", ack_err, 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    run_txn(24'h340E05, 3'b000, 1'b0, 0, 1'b0);
    run_txn(24'h340E05, 3'b010, 1'b0, 0, 1'b0);
    run_txn(24'h340E05, 3'b000, 1'b0, 0, 1'b1);

    go = 1'b1;
    run_txn(24'h400E80, 3'b000, 1'b1, 0, 1'b0);
    run_txn(24'h400E80, 3'b000, 1'b1, 0, 1'b0);
    go = 1'b0;
    repeat (4) @(negedge clk);

    run_txn(24'hA5C3F0, 3'b000, 1'b0, 200, 1'b0);
    run_txn(24'h340E05, 3'b000, 1'b0, 0, 1'b0);

    run_txn(24'h340E05, 3'b001, 1'b0, 0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      rd = 24'($urandom);
      rm = 3'($urandom_range(0, 7));
      run_txn(rd, rm, 1'b0, 0, 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
